// File: rtl/pwm_capture_8.sv
// -----------------------------------------------------------------------------
// pwm_capture_8
//
// Measures a PWM waveform against clk. Latches the high time and the period
// (rising edge to rising edge) of each complete period. Classifies the duty
// cycle against 25/50/75 % of a 256-cycle period, and flags a stuck input when
// no rising edge arrives for 511 cycles.
//
// Parameters
//   TOL       tolerance in clk cycles for the high-time and period windows
//             (keep below 32 so the three duty windows stay disjoint)
//
// Ports
//   clk       single clock; all state updates on its rising edge
//   rst       asynchronous active-low reset, released synchronously to clk
//   pwm_in    PWM waveform, asynchronous to clk
//   high_cnt  [8:0] latched high time of the last complete period
//   period    [8:0] latched period of the last complete period
//   valid     one-cycle pulse when high_cnt/period are updated
//   det_25    last latched period is ~25 % duty (64 of 256)
//   det_50    last latched period is ~50 % duty (128 of 256)
//   det_75    last latched period is ~75 % duty (192 of 256)
//   stuck_lo  no rising edge for 511 cycles, input level low
//   stuck_hi  no rising edge for 511 cycles, input level high
// -----------------------------------------------------------------------------
module pwm_capture_8 #(
   parameter int TOL = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pwm_in,
   output logic [8:0] high_cnt,
   output logic [8:0] period,
   output logic       valid,
   output logic       det_25,
   output logic       det_50,
   output logic       det_75,
   output logic       stuck_lo,
   output logic       stuck_hi
);

   typedef enum logic [1:0] {
      ST_ARM   = 2'd0,
      ST_MEAS  = 2'd1,
      ST_STUCK = 2'd2
   } state_t;

   localparam logic [8:0] TOL_W    = 9'(TOL);
   localparam logic [8:0] CNT_MAX  = 9'd511;
   localparam logic [8:0] PER_NOM  = 9'd256;
   localparam logic [8:0] HI_25    = 9'd64;
   localparam logic [8:0] HI_50    = 9'd128;
   localparam logic [8:0] HI_75    = 9'd192;

   // Window test done purely with unsigned bounds so no intermediate can go
   // negative; every centre used here is well above TOL and well below 511-TOL.
   function automatic logic in_window(input logic [8:0] val, input logic [8:0] center);
      logic [8:0] lo_b;
      logic [8:0] hi_b;
      lo_b = center - TOL_W;
      hi_b = center + TOL_W;
      return (val >= lo_b) && (val <= hi_b);
   endfunction

   state_t     state_r,    state_s;
   logic       sync1_r;
   logic       sync2_r;
   logic       prev_r;
   logic       level_s;
   logic       rise_s;
   logic [8:0] per_cnt_r,  per_cnt_s;
   logic [8:0] hi_cnt_r,   hi_cnt_s;
   logic [8:0] high_cnt_r, high_cnt_s;
   logic [8:0] period_r,   period_s;
   logic       valid_r,    valid_s;
   logic       det_25_r,   det_25_s;
   logic       det_50_r,   det_50_s;
   logic       det_75_r,   det_75_s;
   logic       stuck_lo_r, stuck_lo_s;
   logic       stuck_hi_r, stuck_hi_s;

   // sync2_r is the first metastability-safe copy; prev_r delays it once more
   // so the edge detector never looks at the unsettled first flop.
   assign level_s = sync2_r;
   assign rise_s  = sync2_r & ~prev_r;

   // Input synchronizer and edge-history flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         prev_r  <= 1'b0;
      end else begin
         sync1_r <= pwm_in;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   // Next-state, counter and output computation for the measurement FSM.
   always_comb begin
      state_s    = state_r;
      per_cnt_s  = per_cnt_r;
      hi_cnt_s   = hi_cnt_r;
      high_cnt_s = high_cnt_r;
      period_s   = period_r;
      valid_s    = 1'b0;
      det_25_s   = det_25_r;
      det_50_s   = det_50_r;
      det_75_s   = det_75_r;
      stuck_lo_s = stuck_lo_r;
      stuck_hi_s = stuck_hi_r;

      case (state_r)
         ST_ARM: begin
            // The first edge only opens a measurement; nothing to report yet.
            if (rise_s) begin
               state_s   = ST_MEAS;
               per_cnt_s = 9'd1;
               hi_cnt_s  = 9'd1;
            end else begin
               state_s   = ST_ARM;
            end
         end

         ST_MEAS: begin
            if (rise_s) begin
               // Close the running period and start the next one on this edge.
               period_s   = per_cnt_r;
               high_cnt_s = hi_cnt_r;
               valid_s    = 1'b1;
               det_25_s   = in_window(hi_cnt_r, HI_25) && in_window(per_cnt_r, PER_NOM);
               det_50_s   = in_window(hi_cnt_r, HI_50) && in_window(per_cnt_r, PER_NOM);
               det_75_s   = in_window(hi_cnt_r, HI_75) && in_window(per_cnt_r, PER_NOM);
               per_cnt_s  = 9'd1;
               hi_cnt_s   = 9'd1;
            end else begin
               per_cnt_s = per_cnt_r + 9'd1;
               // hi_cnt never exceeds per_cnt; the guard keeps it from wrapping.
               if (level_s && (hi_cnt_r != CNT_MAX)) begin
                  hi_cnt_s = hi_cnt_r + 9'd1;
               end else begin
                  hi_cnt_s = hi_cnt_r;
               end
               // Counter saturates at 511: give up on this period.
               if (per_cnt_r == (CNT_MAX - 9'd1)) begin
                  state_s    = ST_STUCK;
                  det_25_s   = 1'b0;
                  det_50_s   = 1'b0;
                  det_75_s   = 1'b0;
                  stuck_hi_s = level_s;
                  stuck_lo_s = ~level_s;
               end else begin
                  state_s    = ST_MEAS;
               end
            end
         end

         ST_STUCK: begin
            det_25_s = 1'b0;
            det_50_s = 1'b0;
            det_75_s = 1'b0;
            if (rise_s) begin
               // Recovery edge re-arms like the very first edge after reset.
               state_s    = ST_MEAS;
               per_cnt_s  = 9'd1;
               hi_cnt_s   = 9'd1;
               stuck_hi_s = 1'b0;
               stuck_lo_s = 1'b0;
            end else begin
               stuck_hi_s = level_s;
               stuck_lo_s = ~level_s;
            end
         end

         default: begin
            state_s    = ST_ARM;
            per_cnt_s  = 9'd0;
            hi_cnt_s   = 9'd0;
            det_25_s   = 1'b0;
            det_50_s   = 1'b0;
            det_75_s   = 1'b0;
            stuck_lo_s = 1'b0;
            stuck_hi_s = 1'b0;
         end
      endcase
   end

   // FSM state, running counters and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_ARM;
         per_cnt_r  <= 9'd0;
         hi_cnt_r   <= 9'd0;
         high_cnt_r <= 9'd0;
         period_r   <= 9'd0;
         valid_r    <= 1'b0;
         det_25_r   <= 1'b0;
         det_50_r   <= 1'b0;
         det_75_r   <= 1'b0;
         stuck_lo_r <= 1'b0;
         stuck_hi_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         per_cnt_r  <= per_cnt_s;
         hi_cnt_r   <= hi_cnt_s;
         high_cnt_r <= high_cnt_s;
         period_r   <= period_s;
         valid_r    <= valid_s;
         det_25_r   <= det_25_s;
         det_50_r   <= det_50_s;
         det_75_r   <= det_75_s;
         stuck_lo_r <= stuck_lo_s;
         stuck_hi_r <= stuck_hi_s;
      end
   end

   assign high_cnt = high_cnt_r;
   assign period   = period_r;
   assign valid    = valid_r;
   assign det_25   = det_25_r;
   assign det_50   = det_50_r;
   assign det_75   = det_75_r;
   assign stuck_lo = stuck_lo_r;
   assign stuck_hi = stuck_hi_r;

endmodule

// File: tb/tb_pwm_capture_8.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture_8
//
// Self-checking bench for pwm_capture_8. The reference model keeps the full
// history of applied input samples: period = distance between detected rises,
// high time = number of high samples in that span, duty windows from absolute
// differences. Every cycle the DUT outputs are compared with the model; table
// entries and hand-written sequences add constant expectations on top.
// -----------------------------------------------------------------------------
module tb_pwm_capture_8;

   localparam int TOL = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       pwm_in;
   logic [8:0] high_cnt;
   logic [8:0] period;
   logic       valid;
   logic       det_25, det_50, det_75;
   logic       stuck_lo, stuck_hi;

   pwm_capture_8 #(.TOL(TOL)) dut (
      .clk      (clk),
      .rst      (rst),
      .pwm_in   (pwm_in),
      .high_cnt (high_cnt),
      .period   (period),
      .valid    (valid),
      .det_25   (det_25),
      .det_50   (det_50),
      .det_75   (det_75),
      .stuck_lo (stuck_lo),
      .stuck_hi (stuck_hi)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model state
   bit   hist[$];
   int   mode;        // 0 waiting for first edge, 1 measuring, 2 stuck
   int   last_rise;
   int   e_high, e_per;
   bit   e_valid, e_d25, e_d50, e_d75, e_slo, e_shi;

   // values captured at the most recent DUT valid pulse
   int   valid_seen;
   int   cap_high, cap_per;
   bit   cap_d25, cap_d50, cap_d75;

   typedef struct {
      int h;
      int p;
      int x_high;
      int x_per;
      bit x25;
      bit x50;
      bit x75;
   } vec_t;

   function automatic bit win(int v, int c);
      return ((v - c) <= TOL) && ((c - v) <= TOL);
   endfunction

   task automatic check(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      repeat (3) hist.push_back(1'b0);
      mode = 0;
      last_rise = 0;
      e_high = 0; e_per = 0;
      e_valid = 0; e_d25 = 0; e_d50 = 0; e_d75 = 0; e_slo = 0; e_shi = 0;
   endtask

   // A sample applied at cycle n reaches the edge detector two edges later.
   task automatic model_step(bit lvl);
      int n;
      bit rise;
      int hi;
      hist.push_back(lvl);
      n = hist.size() - 1;
      rise = hist[n-2] && !hist[n-3];
      e_valid = 0;
      if (rise) begin
         if (mode == 1) begin
            hi = 0;
            for (int k = last_rise - 2; k <= n - 3; k++) hi += int'(hist[k]);
            e_per   = n - last_rise;
            e_high  = hi;
            e_valid = 1;
            e_d25 = win(hi, 64)  && win(e_per, 256);
            e_d50 = win(hi, 128) && win(e_per, 256);
            e_d75 = win(hi, 192) && win(e_per, 256);
         end
         mode = 1;
         last_rise = n;
         e_slo = 0;
         e_shi = 0;
      end else if (mode == 1 && (n - last_rise) == 510) begin
         mode = 2;
         e_d25 = 0; e_d50 = 0; e_d75 = 0;
         e_shi = hist[n-2];
         e_slo = !hist[n-2];
      end else if (mode == 2) begin
         e_shi = hist[n-2];
         e_slo = !hist[n-2];
      end
   endtask

   task automatic cyc(bit lvl);
      logic [23:0] got_v, exp_v;
      pwm_in = lvl;
      @(posedge clk);
      model_step(lvl);
      #1;
      got_v = {high_cnt, period, valid, det_25, det_50, det_75, stuck_lo, stuck_hi};
      exp_v = {e_high[8:0], e_per[8:0], e_valid, e_d25, e_d50, e_d75, e_slo, e_shi};
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL cycle %0d: got hc=%0d per=%0d v=%b d=%b%b%b slo=%b shi=%b expected hc=%0d per=%0d v=%b d=%b%b%b slo=%b shi=%b",
                  hist.size() - 4, high_cnt, period, valid, det_25, det_50, det_75, stuck_lo, stuck_hi,
                  e_high, e_per, e_valid, e_d25, e_d50, e_d75, e_slo, e_shi);
      end
      if (valid === 1'b1) begin
         valid_seen++;
         cap_high = int'(high_cnt);
         cap_per  = int'(period);
         cap_d25  = det_25;
         cap_d50  = det_50;
         cap_d75  = det_75;
      end
   endtask

   task automatic wave(int h, int p, int reps);
      for (int r = 0; r < reps; r++) begin
         for (int i = 0; i < h; i++) cyc(1'b1);
         for (int i = h; i < p; i++) cyc(1'b0);
      end
   endtask

   task automatic all_zero(string name);
      check(name, int'({high_cnt, period, valid, det_25, det_50, det_75, stuck_lo, stuck_hi}), 0);
   endtask

   vec_t tbl[11];

   initial begin
      tbl[0]  = '{h:64,  p:256, x_high:64,  x_per:256, x25:1'b1, x50:1'b0, x75:1'b0};
      tbl[1]  = '{h:132, p:256, x_high:132, x_per:256, x25:1'b0, x50:1'b1, x75:1'b0};
      tbl[2]  = '{h:133, p:256, x_high:133, x_per:256, x25:1'b0, x50:1'b0, x75:1'b0};
      tbl[3]  = '{h:124, p:256, x_high:124, x_per:256, x25:1'b0, x50:1'b1, x75:1'b0};
      tbl[4]  = '{h:123, p:256, x_high:123, x_per:256, x25:1'b0, x50:1'b0, x75:1'b0};
      tbl[5]  = '{h:192, p:256, x_high:192, x_per:256, x25:1'b0, x50:1'b0, x75:1'b1};
      tbl[6]  = '{h:196, p:260, x_high:196, x_per:260, x25:1'b0, x50:1'b0, x75:1'b1};
      tbl[7]  = '{h:64,  p:252, x_high:64,  x_per:252, x25:1'b1, x50:1'b0, x75:1'b0};
      tbl[8]  = '{h:64,  p:251, x_high:64,  x_per:251, x25:1'b0, x50:1'b0, x75:1'b0};
      tbl[9]  = '{h:100, p:200, x_high:100, x_per:200, x25:1'b0, x50:1'b0, x75:1'b0};
      tbl[10] = '{h:128, p:261, x_high:128, x_per:261, x25:1'b0, x50:1'b0, x75:1'b0};

      valid_seen = 0;
      cap_high = 0; cap_per = 0; cap_d25 = 0; cap_d50 = 0; cap_d75 = 0;

      // reset state
      rst = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      all_zero("reset_outputs");
      @(negedge clk);
      rst = 1'b1;
      model_reset();

      // 25 % waveform: nothing until the second detected rise
      wave(64, 256, 1);
      check("no_valid_first_period", valid_seen, 0);
      wave(64, 256, 2);
      check("valids_after_3_periods", valid_seen, 2);
      check("p25_high", cap_high, 64);
      check("p25_period", cap_per, 256);
      check("p25_dets", int'({cap_d25, cap_d50, cap_d75}), 3'b100);

      // switch to 75 % mid-stream
      wave(192, 256, 2);
      check("p75_high", cap_high, 192);
      check("p75_dets", int'({cap_d25, cap_d50, cap_d75}), 3'b001);

      // table of window boundaries; the 3rd period of each entry is checked
      for (int i = 0; i < 11; i++) begin
         wave(tbl[i].h, tbl[i].p, 4);
         check($sformatf("tbl%0d_high", i), cap_high, tbl[i].x_high);
         check($sformatf("tbl%0d_period", i), cap_per, tbl[i].x_per);
         check($sformatf("tbl%0d_dets", i), int'({cap_d25, cap_d50, cap_d75}),
               int'({tbl[i].x25, tbl[i].x50, tbl[i].x75}));
      end

      // stuck low after a measurement
      wave(128, 256, 2);
      repeat (600) cyc(1'b0);
      check("stuck_lo_set", int'(stuck_lo), 1);
      check("stuck_lo_hi_clear", int'(stuck_hi), 0);
      check("stuck_lo_dets", int'({det_25, det_50, det_75}), 0);
      check("stuck_lo_period_hold", int'(period), 256);

      // resume 50 % from stuck
      valid_seen = 0;
      wave(128, 256, 1);
      check("resume_stuck_cleared", int'({stuck_lo, stuck_hi}), 0);
      check("resume_no_valid_yet", valid_seen, 0);
      wave(128, 256, 1);
      check("resume_valid_count", valid_seen, 1);
      check("resume_high", cap_high, 128);
      check("resume_period", cap_per, 256);

      // stuck high
      repeat (600) cyc(1'b1);
      check("stuck_hi_set", int'(stuck_hi), 1);
      check("stuck_hi_lo_clear", int'(stuck_lo), 0);
      repeat (20) cyc(1'b0);

      // reset in the middle of a measurement, hi_cnt at 40
      wave(128, 256, 2);
      repeat (42) cyc(1'b1);
      #2;
      rst = 1'b0;
      #1;
      all_zero("midreset_outputs");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      valid_seen = 0;
      repeat (100) cyc(1'b1);
      repeat (156) cyc(1'b0);
      check("midreset_no_valid", valid_seen, 0);
      wave(128, 256, 1);
      check("midreset_valid_count", valid_seen, 1);
      check("midreset_high", cap_high, 100);
      check("midreset_period", cap_per, 256);

      // randomized waveforms, checked cycle by cycle against the model
      for (int w = 0; w < 60; w++) begin
         int p;
         int h;
         if ($urandom_range(2, 0) == 0) begin
            p = 256 + int'($urandom_range(12, 0)) - 6;
            h = 64 * int'($urandom_range(3, 1)) + int'($urandom_range(12, 0)) - 6;
         end else begin
            p = int'($urandom_range(320, 4));
            h = int'($urandom_range(p - 1, 1));
         end
         wave(h, p, int'($urandom_range(3, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
